// File: rtl/nzcv_pkg.sv
// Shared definitions for the NZCV status register: flag bit positions,
// flag-kind encodings and exception FSM states.
package nzcv_pkg;

  localparam int unsigned NZCV_W = 4;
  localparam int unsigned N_BIT  = 3;
  localparam int unsigned Z_BIT  = 2;
  localparam int unsigned C_BIT  = 1;
  localparam int unsigned V_BIT  = 0;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_ADD   = 2'd1,
    KIND_SUB   = 2'd2,
    KIND_LOGIC = 2'd3
  } flag_kind_e;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_EXC    = 1'b1
  } state_e;

endpackage

// File: rtl/nzcv_status_register_if.sv
// EX-stage flag-update bundle plus status outputs. The master drives EX-stage
// results and exception events; the slave is the status register.
interface nzcv_status_register_if
  import nzcv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  logic              valid;
  logic              s_bit;
  logic              cond_pass;
  flag_kind_e        flag_kind;
  logic [DATA_W-1:0] alu_res;
  logic              alu_a_msb;
  logic              alu_b_msb;
  logic              alu_cout;
  logic              shift_cout;
  logic              stall;
  logic              flush;
  logic              exc_enter;
  logic              exc_return;

  logic [NZCV_W-1:0] nzcv;
  logic [NZCV_W-1:0] nzcv_fwd;
  logic [NZCV_W-1:0] saved_nzcv;
  logic              in_exc;
  logic              exc_err;

  modport master (
    output valid, s_bit, cond_pass, flag_kind, alu_res, alu_a_msb, alu_b_msb,
           alu_cout, shift_cout, stall, flush, exc_enter, exc_return,
    input  nzcv, nzcv_fwd, saved_nzcv, in_exc, exc_err
  );

  modport slave (
    input  valid, s_bit, cond_pass, flag_kind, alu_res, alu_a_msb, alu_b_msb,
           alu_cout, shift_cout, stall, flush, exc_enter, exc_return,
    output nzcv, nzcv_fwd, saved_nzcv, in_exc, exc_err
  );

endinterface

// File: rtl/nzcv_flag_calc.sv
// Combinational N/Z/C/V generation from ALU result and operand sign bits.
// Kinds that leave a flag untouched pass the current flag value through.
module nzcv_flag_calc
  import nzcv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  flag_kind_e        i_kind,
  input  logic [DATA_W-1:0] i_res,
  input  logic              i_a_msb,
  input  logic              i_b_msb,
  input  logic              i_cout,
  input  logic              i_shift_cout,
  input  logic [NZCV_W-1:0] i_cur,
  output logic [NZCV_W-1:0] o_nzcv_c
);

  logic w_res_msb;
  logic w_zero;

  assign w_res_msb = i_res[DATA_W-1];
  assign w_zero    = (i_res == '0);

  always_comb begin
    o_nzcv_c = i_cur;
    case (i_kind)
      KIND_ADD: begin
        o_nzcv_c[N_BIT] = w_res_msb;
        o_nzcv_c[Z_BIT] = w_zero;
        o_nzcv_c[C_BIT] = i_cout;
        o_nzcv_c[V_BIT] = (i_a_msb == i_b_msb) && (w_res_msb != i_a_msb);
      end
      // b_msb is the un-inverted operand, so overflow needs differing signs.
      KIND_SUB: begin
        o_nzcv_c[N_BIT] = w_res_msb;
        o_nzcv_c[Z_BIT] = w_zero;
        o_nzcv_c[C_BIT] = i_cout;
        o_nzcv_c[V_BIT] = (i_a_msb != i_b_msb) && (w_res_msb != i_a_msb);
      end
      KIND_LOGIC: begin
        o_nzcv_c[N_BIT] = w_res_msb;
        o_nzcv_c[Z_BIT] = w_zero;
        o_nzcv_c[C_BIT] = i_shift_cout;
      end
      default: o_nzcv_c = i_cur;
    endcase
  end

endmodule

// File: rtl/nzcv_status_register.sv
// Architectural NZCV status register with exception save/restore FSM.
// Optional macro NZCV_BYPASS_EN adds a combinational bypass onto nzcv_fwd.
module nzcv_status_register
  import nzcv_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [NZCV_W-1:0] RESET_NZCV = 4'b0000
) (
  input logic                   clk,
  input logic                   rst_n,
  nzcv_status_register_if.slave bus
);

  state_e            r_state;
  logic [NZCV_W-1:0] r_nzcv;
  logic [NZCV_W-1:0] r_saved;
  logic              r_err;

  state_e            w_state_nxt;
  logic [NZCV_W-1:0] w_nzcv_nxt;
  logic [NZCV_W-1:0] w_saved_nxt;
  logic              w_err_nxt;

  logic [NZCV_W-1:0] w_calc;
  logic              w_upd;
  logic              w_hold;

  nzcv_flag_calc #(
    .DATA_W (DATA_W)
  ) u_flag_calc (
    .i_kind       (bus.flag_kind),
    .i_res        (bus.alu_res),
    .i_a_msb      (bus.alu_a_msb),
    .i_b_msb      (bus.alu_b_msb),
    .i_cout       (bus.alu_cout),
    .i_shift_cout (bus.shift_cout),
    .i_cur        (r_nzcv),
    .o_nzcv_c     (w_calc)
  );

  assign w_upd  = bus.valid & bus.s_bit & bus.cond_pass &
                  (bus.flag_kind != KIND_NONE) & ~bus.flush;
  // A flush overrides a stall so the kill always lands.
  assign w_hold = bus.stall & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_NORMAL;
      r_nzcv  <= RESET_NZCV;
      r_saved <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_nzcv  <= w_nzcv_nxt;
      r_saved <= w_saved_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Priority: hold, exception return, exception entry, plain flag update.
  always_comb begin
    w_state_nxt = r_state;
    w_nzcv_nxt  = r_nzcv;
    w_saved_nxt = r_saved;
    w_err_nxt   = r_err;
    if (!w_hold) begin
      if (bus.exc_return) begin
        if (r_state == S_EXC) begin
          w_nzcv_nxt  = r_saved;
          w_state_nxt = S_NORMAL;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else if (bus.exc_enter) begin
        if (r_state == S_NORMAL) begin
          w_saved_nxt = w_upd ? w_calc : r_nzcv;
          w_state_nxt = S_EXC;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else if (w_upd) begin
        w_nzcv_nxt = w_calc;
      end
    end
  end

  assign bus.nzcv       = r_nzcv;
  assign bus.saved_nzcv = r_saved;
  assign bus.in_exc     = (r_state == S_EXC);
  assign bus.exc_err    = r_err;

`ifdef NZCV_BYPASS_EN
  assign bus.nzcv_fwd = w_upd ? w_calc : r_nzcv;
`else
  assign bus.nzcv_fwd = r_nzcv;
`endif

endmodule

// File: tb/tb_nzcv_status_register.sv
// Scoreboard bench for nzcv_status_register: directed cases then random traffic
// against an arithmetic reference model. Honours NZCV_BYPASS_EN for nzcv_fwd.
module tb_nzcv_status_register;
  import nzcv_pkg::*;

  typedef struct {
    logic [3:0] fwd;
    logic [3:0] nzcv;
    logic [3:0] saved;
    logic       exc;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t sbq[$];

  logic [3:0] m_nzcv;
  logic [3:0] m_saved;
  bit         m_exc;
  bit         m_err;

  nzcv_status_register_if #(.DATA_W(32)) bus ();

  nzcv_status_register #(
    .DATA_W     (32),
    .RESET_NZCV (4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_idle();
    bus.valid = 1'b0; bus.s_bit = 1'b0; bus.cond_pass = 1'b0;
    bus.flag_kind = KIND_NONE; bus.alu_res = '0; bus.alu_a_msb = 1'b0;
    bus.alu_b_msb = 1'b0; bus.alu_cout = 1'b0; bus.shift_cout = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.exc_enter = 1'b0; bus.exc_return = 1'b0;
  endtask

  task automatic model_reset();
    m_nzcv = 4'b0000; m_saved = 4'b0000; m_exc = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_nzcv"},  bus.nzcv, 4'b0000);
    chk({tag, "_saved"}, bus.saved_nzcv, 4'b0000);
    chk({tag, "_fwd"},   bus.nzcv_fwd, 4'b0000);
    chk({tag, "_inexc"}, {3'b000, bus.in_exc}, 4'b0000);
    chk({tag, "_err"},   {3'b000, bus.exc_err}, 4'b0000);
  endtask

  // One EX-stage cycle: operands are given arithmetically; the bench forms the
  // ALU result/carry itself and predicts flags from signed/unsigned range checks.
  task automatic issue(input bit v, input bit s, input bit cp, input int kind,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lres, input bit shc,
                       input bit st, input bit fl, input bit en, input bit rt);
    logic [31:0] res;
    logic        cout;
    logic        c_exp;
    logic        v_exp;
    longint      sa;
    longint      sb;
    longint      sr;
    logic [3:0]  nxt;
    bit          upd;
    exp_t        e;
    sa = $signed(a);
    sb = $signed(b);
    v_exp = m_nzcv[0];
    c_exp = m_nzcv[1];
    cout  = 1'($urandom % 2);
    res   = lres;
    case (kind)
      1: begin
        res   = a + b;
        cout  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        sr    = sa + sb;
        c_exp = cout;
        v_exp = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2: begin
        res   = a - b;
        cout  = (a >= b);
        sr    = sa - sb;
        c_exp = cout;
        v_exp = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3: c_exp = shc;
      default: ;
    endcase
    nxt = {res[31], (res == 32'd0), c_exp, v_exp};
    upd = v && s && cp && (kind != 0) && !fl;

    @(negedge clk);
    bus.valid = v; bus.s_bit = s; bus.cond_pass = cp;
    bus.flag_kind = flag_kind_e'(2'(kind)); bus.alu_res = res;
    bus.alu_a_msb = a[31]; bus.alu_b_msb = b[31]; bus.alu_cout = cout;
    bus.shift_cout = shc; bus.stall = st; bus.flush = fl;
    bus.exc_enter = en; bus.exc_return = rt;

`ifdef NZCV_BYPASS_EN
    e.fwd = upd ? nxt : m_nzcv;
`else
    e.fwd = m_nzcv;
`endif
    if (!(st && !fl)) begin
      if (rt) begin
        if (m_exc) begin m_nzcv = m_saved; m_exc = 1'b0; end
        else m_err = 1'b1;
      end else if (en) begin
        if (!m_exc) begin m_saved = upd ? nxt : m_nzcv; m_exc = 1'b1; end
        else m_err = 1'b1;
      end else if (upd) begin
        m_nzcv = nxt;
      end
    end
    e.nzcv = m_nzcv; e.saved = m_saved; e.exc = m_exc; e.err = m_err;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = pick();
      b = ($urandom % 6 == 0) ? a : pick();
      issue(($urandom % 100) < 85, ($urandom % 100) < 75, ($urandom % 100) < 75,
            int'($urandom % 4), a, b, pick(), 1'($urandom % 2),
            ($urandom % 100) < 15, ($urandom % 100) < 10,
            ($urandom % 100) < 8, ($urandom % 100) < 8);
    end
  endtask

  // Wait for the monitor to consume everything, bounded.
  task automatic drain();
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: pops an expectation, checks bypass output before the edge and
  // registered state after it.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        it = sbq.pop_front();
        chk("nzcv_fwd", bus.nzcv_fwd, it.fwd);
        @(posedge clk);
        #1;
        chk("nzcv", bus.nzcv, it.nzcv);
        chk("saved_nzcv", bus.saved_nzcv, it.saved);
        chk("in_exc", {3'b000, bus.in_exc}, {3'b000, it.exc});
        chk("exc_err", {3'b000, bus.exc_err}, {3'b000, it.err});
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD overflow 0x7FFFFFFF + 1 -> N and V.
    issue(1, 1, 1, 1, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 0, 0, 0, 0);
    // SUB 5-5 -> Z and C; then the same with cond_pass low.
    issue(1, 1, 1, 2, 32'd5, 32'd5, 32'h0, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 1, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 0, 0, 0, 0);
    // Enter exception, LOGIC update inside, then return restores.
    issue(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    issue(1, 1, 1, 3, 32'h0, 32'h0, 32'h8000_0000, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    // Stall freezes update and entry; stall+flush kills the update.
    issue(1, 1, 1, 1, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 1, 0, 1, 0);
    issue(1, 1, 1, 1, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 1, 1, 0, 0);
    // Return while not in an exception -> sticky error.
    issue(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    issue(1, 1, 1, 2, 32'd3, 32'd9, 32'h0, 0, 0, 0, 0, 0);
    // Enter and return together: return wins (not in exception -> error).
    issue(1, 1, 1, 1, 32'h1, 32'h1, 32'h0, 0, 0, 0, 1, 1);

    random_cycles(400);
    drain();

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #1;
    rst_n = 1'b1;

    random_cycles(200);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
